// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus bundle: memory request/response, decoder head, and redirects.
// The master modport is the fetch unit; slave is its memory/decoder/ROB environment.
interface inst_fetch_queue_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_done;
   logic [31:0] mem_data;
   logic        inst_valid;
   logic [31:0] inst_pc;
   logic [31:0] inst;
   logic        inst_pred_taken;
   logic        dec_ready;
   logic        flush_in;
   logic [31:0] flush_pc;
   logic        jalr_done_in;
   logic [31:0] jalr_pc_in;
   logic        queue_full;

   modport master (
      output mem_req, mem_addr, inst_valid, inst_pc, inst, inst_pred_taken, queue_full,
      input  mem_done, mem_data, dec_ready, flush_in, flush_pc, jalr_done_in, jalr_pc_in
   );

   modport slave (
      input  mem_req, mem_addr, inst_valid, inst_pc, inst, inst_pred_taken, queue_full,
      output mem_done, mem_data, dec_ready, flush_in, flush_pc, jalr_done_in, jalr_pc_in
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: owns the fetch PC, issues one memory request at a time and
// buffers results in a show-ahead FIFO. Optional PREDICT_BTFN_EN: backward branches taken.
//
// state  | meaning
// IDLE   | ready to issue the next fetch when a FIFO slot is free
// WAIT   | request outstanding, waiting for mem_done
// JSTALL | JALR fetched, waiting for the resolved target
// DROP   | request outstanding but flushed; its data is thrown away
module inst_fetch_queue #(
   parameter int          QUEUE_DEPTH_BIT = 3,
   parameter logic [31:0] RESET_PC        = 32'h0
) (
   input logic                 clk_in,
   input logic                 rst_in,
   input logic                 rdy_in,
   inst_fetch_queue_if.master  ifq
);
   localparam int          DEPTH   = 1 << QUEUE_DEPTH_BIT;
   localparam logic [6:0]  OP_JAL  = 7'b1101111;
   localparam logic [6:0]  OP_JALR = 7'b1100111;
`ifdef PREDICT_BTFN_EN
   localparam logic [6:0]  OP_BR   = 7'b1100011;
`endif

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_JSTALL, S_DROP} state_t;

   state_t                   r_state, w_state_nxt;
   logic [31:0]              r_fetch_pc, w_fetch_pc_nxt;
   logic                     r_mem_req, w_mem_req_nxt;
   logic [31:0]              r_mem_addr, w_mem_addr_nxt;
   logic [QUEUE_DEPTH_BIT-1:0] r_wr_ptr, r_rd_ptr;
   logic [QUEUE_DEPTH_BIT:0] r_count;
   logic [31:0]              r_pc_mem   [DEPTH];
   logic [31:0]              r_inst_mem [DEPTH];
   logic                     w_push, w_pop, w_full, w_empty;
   logic [31:0]              w_imm_j;
`ifdef PREDICT_BTFN_EN
   logic                     r_pred_mem [DEPTH];
   logic                     w_pred;
   logic [31:0]              w_imm_b;
`endif

   // Count never exceeds DEPTH, so its top bit alone marks a full queue.
   assign w_full  = r_count[QUEUE_DEPTH_BIT];
   assign w_empty = (r_count == '0);
   assign w_pop   = !w_empty && ifq.dec_ready && rdy_in && !ifq.flush_in;

   assign w_imm_j = {{12{ifq.mem_data[31]}}, ifq.mem_data[19:12], ifq.mem_data[20],
                     ifq.mem_data[30:21], 1'b0};
`ifdef PREDICT_BTFN_EN
   assign w_imm_b = {{20{ifq.mem_data[31]}}, ifq.mem_data[7], ifq.mem_data[30:25],
                     ifq.mem_data[11:8], 1'b0};
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_mem_req_nxt  = r_mem_req;
      w_mem_addr_nxt = r_mem_addr;
      w_push         = 1'b0;
`ifdef PREDICT_BTFN_EN
      w_pred         = 1'b0;
`endif
      if (ifq.flush_in) begin
         w_fetch_pc_nxt = ifq.flush_pc;
         // A request still in flight must be drained before a new one may issue.
         if ((r_state == S_WAIT || r_state == S_DROP) && !ifq.mem_done) begin
            w_state_nxt = S_DROP;
         end else begin
            w_state_nxt   = S_IDLE;
            w_mem_req_nxt = 1'b0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_full) begin
                  w_mem_req_nxt  = 1'b1;
                  w_mem_addr_nxt = r_fetch_pc;
                  w_state_nxt    = S_WAIT;
               end
            end
            S_WAIT: begin
               if (ifq.mem_done) begin
                  w_push        = 1'b1;
                  w_mem_req_nxt = 1'b0;
                  w_state_nxt   = S_IDLE;
                  if (ifq.mem_data[6:0] == OP_JAL) begin
                     w_fetch_pc_nxt = r_fetch_pc + w_imm_j;
                  end else if (ifq.mem_data[6:0] == OP_JALR) begin
                     w_state_nxt = S_JSTALL;
`ifdef PREDICT_BTFN_EN
                  end else if (ifq.mem_data[6:0] == OP_BR && w_imm_b[31]) begin
                     w_fetch_pc_nxt = r_fetch_pc + w_imm_b;
                     w_pred         = 1'b1;
`endif
                  end else begin
                     w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                  end
               end
            end
            S_JSTALL: begin
               if (ifq.jalr_done_in) begin
                  w_fetch_pc_nxt = ifq.jalr_pc_in;
                  w_state_nxt    = S_IDLE;
               end
            end
            S_DROP: begin
               if (ifq.mem_done) begin
                  w_mem_req_nxt = 1'b0;
                  w_state_nxt   = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= RESET_PC;
         r_mem_req  <= 1'b0;
         r_mem_addr <= 32'h0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
      end else if (rdy_in) begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_mem_req  <= w_mem_req_nxt;
         r_mem_addr <= w_mem_addr_nxt;
         if (ifq.flush_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rdy_in && w_push) begin
         r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
         r_inst_mem[r_wr_ptr] <= ifq.mem_data;
`ifdef PREDICT_BTFN_EN
         r_pred_mem[r_wr_ptr] <= w_pred;
`endif
      end
   end

   assign ifq.mem_req    = r_mem_req;
   assign ifq.mem_addr   = r_mem_addr;
   assign ifq.inst_valid = !w_empty;
   assign ifq.inst_pc    = r_pc_mem[r_rd_ptr];
   assign ifq.inst       = r_inst_mem[r_rd_ptr];
   assign ifq.queue_full = w_full;
`ifdef PREDICT_BTFN_EN
   assign ifq.inst_pred_taken = !w_empty && r_pred_mem[r_rd_ptr];
`else
   assign ifq.inst_pred_taken = 1'b0;
`endif
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: memory responder, transaction-level fetch model and
// directed scenarios (sequential, full queue, JAL, JALR, flush, branch prediction).
module tb_inst_fetch_queue;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
      logic        pred;
   } ent_t;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   logic rdy_in = 1'b1;
   inst_fetch_queue_if ifq ();

   inst_fetch_queue dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .ifq(ifq));

   always #5 clk_in = ~clk_in;

   int n_chk = 0;
   int n_err = 0;
   bit en = 1'b0;
   int mem_lat = 1;
   int r_cnt = 0;

   logic [31:0] mem_img [logic [31:0]];
   ent_t        exp_q [$];
   ent_t        pop_log [$];
   logic [31:0] req_log [$];
   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_req_addr = 32'h0;
   bit          m_stall = 1'b0;
   bit          m_drop = 1'b0;
   bit          prev_req = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_chk++;
      n_err++;
      $display("FAIL %s: timed out waiting for fetch request", nm);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return mem_img.exists(a) ? mem_img[a] : 32'h0000_0013;
   endfunction

   function automatic logic [31:0] req_at(input int i);
      return (req_log.size() > i) ? req_log[i] : 32'hdead_beef;
   endfunction

   function automatic ent_t pop_at(input int i);
      ent_t e;
      e = '{pc: 32'hdead_beef, ins: 32'hdead_beef, pred: 1'b1};
      if (pop_log.size() > i) e = pop_log[i];
      return e;
   endfunction

   // Architectural next-PC rule: where the instruction word sends the fetch stream.
   function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w,
                                           output logic pred, output bit stall);
      int signed off;
      pred  = 1'b0;
      stall = 1'b0;
      if (w[6:0] == 7'b1101111) begin
         off = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
         return pc + 32'(off);
      end
      if (w[6:0] == 7'b1100111) begin
         stall = 1'b1;
         return pc;
      end
`ifdef PREDICT_BTFN_EN
      if (w[6:0] == 7'b1100011 && w[31]) begin
         off  = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
         pred = 1'b1;
         return pc + 32'(off);
      end
`endif
      return pc + 32'd4;
   endfunction

   // Memory: answers each request mem_lat cycles after it is first seen.
   always begin
      @(posedge clk_in);
      #1;
      ifq.mem_done = 1'b0;
      if (rst_in && rdy_in) begin
         if (ifq.mem_req) begin
            r_cnt++;
            if (r_cnt >= mem_lat) begin
               ifq.mem_done = 1'b1;
               ifq.mem_data = mem_word(ifq.mem_addr);
               r_cnt = 0;
            end
         end else begin
            r_cnt = 0;
         end
      end
   end

   // Compare against the model, then advance the model with this cycle's inputs.
   always @(negedge clk_in) begin
      if (en) begin
         ent_t e;
         logic p;
         bit   s;
         chk("inst_valid", ifq.inst_valid, 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            chk("inst_pc", ifq.inst_pc, exp_q[0].pc);
            chk("inst", ifq.inst, exp_q[0].ins);
            chk("inst_pred_taken", ifq.inst_pred_taken, exp_q[0].pred);
         end
         chk("queue_full", ifq.queue_full, 32'(exp_q.size() == 8));
         if (ifq.mem_req && !prev_req) begin
            chk("req_addr", ifq.mem_addr, m_pc);
            chk("req_while_blocked", ifq.mem_req, 32'(!(m_stall || m_drop)));
            m_req_addr = m_pc;
            req_log.push_back(ifq.mem_addr);
         end else if (ifq.mem_req) begin
            chk("req_addr_stable", ifq.mem_addr, m_req_addr);
         end
         prev_req = ifq.mem_req;
         if (rdy_in && ifq.inst_valid && ifq.dec_ready && !ifq.flush_in)
            pop_log.push_back('{pc: ifq.inst_pc, ins: ifq.inst, pred: ifq.inst_pred_taken});

         if (rdy_in) begin
            if (ifq.flush_in) begin
               exp_q.delete();
               m_pc    = ifq.flush_pc;
               m_stall = 1'b0;
               m_drop  = ifq.mem_req && !ifq.mem_done;
            end else begin
               if (exp_q.size() != 0 && ifq.dec_ready) void'(exp_q.pop_front());
               if (ifq.mem_done) begin
                  if (m_drop) begin
                     m_drop = 1'b0;
                  end else begin
                     e.pc  = m_pc;
                     e.ins = ifq.mem_data;
                     m_pc  = next_pc(m_pc, ifq.mem_data, p, s);
                     e.pred = p;
                     m_stall = s;
                     exp_q.push_back(e);
                  end
               end else if (m_stall && ifq.jalr_done_in) begin
                  m_pc    = ifq.jalr_pc_in;
                  m_stall = 1'b0;
               end
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic do_flush(input logic [31:0] pc);
      @(posedge clk_in);
      #1;
      ifq.flush_in = 1'b1;
      ifq.flush_pc = pc;
      @(posedge clk_in);
      #1;
      ifq.flush_in = 1'b0;
      req_log.delete();
      pop_log.delete();
   endtask

   task automatic wait_req(input int n, input int budget, input string nm);
      int k;
      k = 0;
      while (req_log.size() < n && k < budget) begin
         @(posedge clk_in);
         #1;
         k++;
      end
      if (req_log.size() < n) timeout(nm);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      ent_t e;
      ifq.mem_done     = 1'b0;
      ifq.mem_data     = 32'h0;
      ifq.dec_ready    = 1'b1;
      ifq.flush_in     = 1'b0;
      ifq.flush_pc     = 32'h0;
      ifq.jalr_done_in = 1'b0;
      ifq.jalr_pc_in   = 32'h0;
      #2 rst_in = 1'b0;
      #20;
      chk("rst_mem_req", ifq.mem_req, 0);
      chk("rst_mem_addr", ifq.mem_addr, 0);
      chk("rst_inst_valid", ifq.inst_valid, 0);
      chk("rst_pred", ifq.inst_pred_taken, 0);
      chk("rst_queue_full", ifq.queue_full, 0);
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      en = 1'b1;

      // Sequential fetch with a nop stream
      wait_req(3, 20, "t1_req");
      cyc(6);
      chk("t1_req0", req_at(0), 32'h0);
      chk("t1_req1", req_at(1), 32'h4);
      chk("t1_req2", req_at(2), 32'h8);
      chk("t1_pop0", pop_at(0).pc, 32'h0);
      chk("t1_pop1", pop_at(1).pc, 32'h4);
      chk("t1_pop2", pop_at(2).pc, 32'h8);

      // Fill the queue with the decoder stalled
      ifq.dec_ready = 1'b0;
      do_flush(32'h0);
      cyc(40);
      chk("t2_nreq", req_log.size(), 8);
      chk("t2_last_req", req_at(7), 32'h1c);
      chk("t2_full", ifq.queue_full, 1);
      chk("t2_req_low", ifq.mem_req, 0);
      ifq.dec_ready = 1'b1;
      wait_req(9, 20, "t2_resume");
      chk("t2_next_req", req_at(8), 32'h20);
      cyc(10);

      // JAL +16 at 0x10
      mem_img.delete();
      mem_img[32'h10] = 32'h0100006f;
      do_flush(32'h0);
      wait_req(6, 40, "t3_req");
      chk("t3_req_jal", req_at(4), 32'h10);
      chk("t3_req_tgt", req_at(5), 32'h20);
      cyc(4);
      e = pop_at(4);
      chk("t3_pop_pc", e.pc, 32'h10);
      chk("t3_pop_inst", e.ins, 32'h0100006f);

      // JALR at 0x8 stalls until the target resolves
      mem_img.delete();
      mem_img[32'h8] = 32'h00008067;
      do_flush(32'h0);
      cyc(8);
      cyc(10);
      chk("t4_nreq_stall", req_log.size(), 3);
      chk("t4_req_low", ifq.mem_req, 0);
      ifq.jalr_done_in = 1'b1;
      ifq.jalr_pc_in   = 32'h100;
      cyc(1);
      ifq.jalr_done_in = 1'b0;
      wait_req(4, 10, "t4_resume");
      chk("t4_req_tgt", req_at(3), 32'h100);
      e = pop_at(2);
      chk("t4_pop_pc", e.pc, 32'h8);
      chk("t4_pop_inst", e.ins, 32'h00008067);

      // Flush while the request to 0x14 is outstanding
      mem_img.delete();
      mem_img[32'h14] = 32'h00100093;
      mem_lat = 5;
      do_flush(32'h0);
      wait_req(6, 80, "t5_req");
      chk("t5_req_014", req_at(5), 32'h14);
      ifq.flush_in = 1'b1;
      ifq.flush_pc = 32'h40;
      @(posedge clk_in);
      #1;
      ifq.flush_in = 1'b0;
      req_log.delete();
      pop_log.delete();
      chk("t5_valid_after_flush", ifq.inst_valid, 0);
      wait_req(1, 30, "t5_redirect");
      chk("t5_req_redirect", req_at(0), 32'h40);
      cyc(14);
      chk("t5_first_pop", pop_at(0).pc, 32'h40);
      mem_lat = 1;

      // Backward branch at 0x24
      mem_img.delete();
      mem_img[32'h24] = 32'hfe000ee3;
      do_flush(32'h24);
      wait_req(2, 20, "t6_req");
      chk("t6_req_br", req_at(0), 32'h24);
`ifdef PREDICT_BTFN_EN
      chk("t6_req_next", req_at(1), 32'h20);
`else
      chk("t6_req_next", req_at(1), 32'h28);
`endif
      cyc(4);
      e = pop_at(0);
      chk("t6_pop_pc", e.pc, 32'h24);
`ifdef PREDICT_BTFN_EN
      chk("t6_pop_pred", e.pred, 1);
`else
      chk("t6_pop_pred", e.pred, 0);
`endif

      // Global pause mid-stream
      mem_img.delete();
      do_flush(32'h80);
      cyc(5);
      rdy_in = 1'b0;
      cyc(5);
      rdy_in = 1'b1;
      cyc(10);

      // Flush and JALR resolution in the same cycle: flush target wins
      mem_img[32'h8] = 32'h00008067;
      do_flush(32'h0);
      cyc(12);
      ifq.flush_in     = 1'b1;
      ifq.flush_pc     = 32'h200;
      ifq.jalr_done_in = 1'b1;
      ifq.jalr_pc_in   = 32'h300;
      @(posedge clk_in);
      #1;
      ifq.flush_in     = 1'b0;
      ifq.jalr_done_in = 1'b0;
      req_log.delete();
      pop_log.delete();
      wait_req(1, 10, "t8_req");
      chk("t8_req_flush_wins", req_at(0), 32'h200);
      cyc(6);

      en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Producer end of the decoder's instruction interface: fetches 32-bit instructions from the memory controller, buffers them in a FIFO, and presents valid/pc/inst to the decoder.
- Owns the fetch PC: sequential +4, JAL target, stall on JALR until the target resolves, redirect on ROB flush.
- Sits between the memory controller/arbiter and the decoder.

Parameters:
QUEUE_DEPTH_BIT, 3, log2 of FIFO entries (default 8)
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous active-low reset
rdy_in  input  1  global pause when low
mem_req  output  1  fetch request, held until mem_done
mem_addr  output  32  fetch address, stable while mem_req high
mem_done  input  1  one-cycle pulse: mem_data valid for the outstanding request
mem_data  input  32  fetched instruction word
inst_valid  output  1  FIFO head valid (FIFO not empty)
inst_pc  output  32  PC of head entry
inst  output  32  instruction of head entry
inst_pred_taken  output  1  predicted-taken flag of head entry
dec_ready  input  1  decoder consumes head this cycle
flush_in  input  1  ROB mispredict redirect
flush_pc  input  32  redirect target
jalr_done_in  input  1  JALR target resolved
jalr_pc_in  input  32  JALR target
queue_full  output  1  FIFO holds 2^QUEUE_DEPTH_BIT entries

Behaviour:
- Reset (rst_in=0, async): state IDLE, fetch_pc=RESET_PC, FIFO empty with pointers and count 0, mem_req=0, mem_addr=0. inst_valid=0, inst_pred_taken=0, queue_full=0.
- rdy_in=0: all registers hold. No push, pop or state change. The memory controller never pulses mem_done while rdy_in=0.
- FIFO: show-ahead. inst/inst_pc/inst_pred_taken come combinationally from the head entry.
  - Pop when inst_valid && dec_ready && rdy_in.
  - Pointers are QUEUE_DEPTH_BIT wide and wrap naturally. Count is QUEUE_DEPTH_BIT+1 bits.
  - Push and pop in the same cycle are legal at any occupancy.
- At most one request is outstanding. A request is issued only when count < depth, which reserves a slot, so a push never overflows.
- FSM:
  - IDLE: if FIFO not full, register mem_req=1 and mem_addr=fetch_pc, then go to WAIT. Otherwise stay.
  - WAIT: on mem_done, push {fetch_pc, mem_data, pred} and drop mem_req next cycle.
    - Next fetch_pc: JAL (opcode 1101111) -> fetch_pc+imm_j. JALR (1100111) -> JSTALL. Otherwise fetch_pc+4.
    - Then go to IDLE unless entering JSTALL.
  - JSTALL: no requests. On jalr_done_in, fetch_pc=jalr_pc_in and go to IDLE.
  - DROP: mem_req held. On mem_done, discard the data and go to IDLE.
- Latency: mem_req rises one cycle after the IDLE decision. Data accepted on mem_done appears at inst_valid the next cycle.
- flush_in has highest priority, in any state:
  - FIFO cleared; fetch_pc=flush_pc; pending JALR stall cancelled.
  - In WAIT without mem_done that cycle: go to DROP.
  - In WAIT with mem_done that cycle: discard the data and go to IDLE.
  - Otherwise: go to IDLE.
  - inst_valid is 0 the cycle after a flush.
- flush_in and jalr_done_in together: flush wins and jalr_done_in is ignored.
- A pop and a flush in the same cycle: the flush wins.
- imm_j arithmetic is 32-bit modulo. fetch_pc wraps at 2^32.

Optional Feature:
Macro PREDICT_BTFN_EN.
- Defined: conditional branches (opcode 1100011) with negative imm_b are predicted taken. Next fetch_pc=fetch_pc+imm_b and the entry's pred bit is 1. Forward branches use +4 with pred bit 0.
- Undefined: all branches use +4 and inst_pred_taken is constant 0.

Test Plan:
1. Reset, RESET_PC=0; memory returns 32'h00000013 with 1-cycle latency; dec_ready=1 -> mem_addr 0,4,8,...; inst_valid entries delivered in order with inst_pc 0,4,8.
2. dec_ready=0, depth 8 -> exactly 8 requests (0x0-0x1C), then queue_full=1 and mem_req stays 0. Raise dec_ready -> next mem_addr=0x20.
3. JAL 32'h0100006f fetched at 0x10 -> next mem_addr=0x20; entry at 0x10 delivered.
4. JALR 32'h00008067 at 0x8 -> no mem_req for 10 cycles. Pulse jalr_done_in with jalr_pc_in=0x100 -> next mem_addr=0x100; the JALR entry is still delivered.
5. Request to 0x14 outstanding; flush_in with flush_pc=0x40; mem_done 3 cycles later -> data discarded, inst_valid=0 after the flush, next mem_addr=0x40.
6. PREDICT_BTFN_EN defined: 32'hfe000ee3 (beq -4) at 0x24 -> next mem_addr=0x20 and inst_pred_taken=1 for that entry. Undefined: next mem_addr=0x28 and inst_pred_taken=0.
